// File: rtl/circ_buf_ctrl.sv
// Handshake controller for the circular-buffer datapath: producer/consumer level-req/pulse-ack to write_en/cntW/cntR strobes.
// Optional transfer statistics counters are built when CIRC_BUF_CTRL_STATS_EN is defined.
module circ_buf_ctrl #(
    parameter int STALL_LIMIT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             put_req,
    output logic             put_ack,
    input  logic             get_req,
    output logic             get_ack,
    input  logic             dp_ready,
    input  logic             dp_valid,
    output logic             dp_write_en,
    output logic             dp_cntW,
    output logic             dp_cntR,
    input  logic             err_clr,
    output logic             put_stall,
    output logic             get_stall,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] rd_count
);

    typedef enum logic [1:0] {W_IDLE, W_PUSH, W_WAIT} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_POP, R_WAIT} r_state_t;

    localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

    w_state_t   w_state, w_next;
    r_state_t   r_state, r_next;
    logic [7:0] w_stall_cnt, r_stall_cnt;
    logic       w_blocked, r_blocked;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // Outputs decode the registered state only, so no input reaches an output combinationally.
    always_comb begin
        w_next      = w_state;
        put_ack     = 1'b0;
        dp_write_en = 1'b0;
        dp_cntW     = 1'b0;
        unique case (w_state)
            W_IDLE: if (put_req && dp_ready) w_next = W_PUSH;
            W_PUSH: begin
                put_ack     = 1'b1;
                dp_write_en = 1'b1;
                dp_cntW     = 1'b1;
                w_next      = W_WAIT;
            end
            W_WAIT: if (!put_req) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next  = r_state;
        get_ack = 1'b0;
        dp_cntR = 1'b0;
        unique case (r_state)
            R_IDLE: if (get_req && dp_valid) r_next = R_POP;
            R_POP: begin
                get_ack = 1'b1;
                dp_cntR = 1'b1;
                r_next  = R_WAIT;
            end
            R_WAIT: if (!get_req) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    assign w_blocked = (w_state == W_IDLE) && put_req && !dp_ready;
    assign r_blocked = (r_state == R_IDLE) && get_req && !dp_valid;

    // Flag sets on the edge where the counter reaches the limit; err_clr wins over a same-cycle set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_stall_cnt <= '0;
            put_stall   <= 1'b0;
        end else if (err_clr) begin
            w_stall_cnt <= '0;
            put_stall   <= 1'b0;
        end else if (w_blocked) begin
            if (w_stall_cnt != LIMIT) w_stall_cnt <= w_stall_cnt + 8'd1;
            if (w_stall_cnt >= LIMIT - 8'd1) put_stall <= 1'b1;
        end else begin
            w_stall_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            get_stall   <= 1'b0;
        end else if (err_clr) begin
            r_stall_cnt <= '0;
            get_stall   <= 1'b0;
        end else if (r_blocked) begin
            if (r_stall_cnt != LIMIT) r_stall_cnt <= r_stall_cnt + 8'd1;
            if (r_stall_cnt >= LIMIT - 8'd1) get_stall <= 1'b1;
        end else begin
            r_stall_cnt <= '0;
        end
    end

`ifdef CIRC_BUF_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (w_state == W_PUSH) wr_count <= wr_count + CNT_W'(1);
            if (r_state == R_POP)  rd_count <= rd_count + CNT_W'(1);
        end
    end
`else
    assign wr_count = '0;
    assign rd_count = '0;
`endif

endmodule

// File: tb/tb_circ_buf_ctrl.sv
// Self-checking bench for circ_buf_ctrl: directed scenarios plus randomized traffic against a rule-based reference model.
module tb_circ_buf_ctrl;

    localparam int L  = 4;
    localparam int CW = 4;
`ifdef CIRC_BUF_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          put_req = 1'b0, get_req = 1'b0;
    logic          dp_ready = 1'b0, dp_valid = 1'b0, err_clr = 1'b0;
    logic          put_ack, get_ack, dp_write_en, dp_cntW, dp_cntR, put_stall, get_stall;
    logic [CW-1:0] wr_count, rd_count;

    int checks = 0;
    int failures = 0;

    // Reference model: per side, whether a new transfer may be admitted, edges since the last
    // admission, expected ack in the current cycle, blocked-cycle count, sticky flag, transfers done.
    bit w_armed, r_armed;
    int w_since, r_since;
    bit w_ack, r_ack;
    int w_cnt, r_cnt;
    bit w_stall, r_stall;
    int wn, rn;

    circ_buf_ctrl #(.STALL_LIMIT(L), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .put_req(put_req), .put_ack(put_ack),
        .get_req(get_req), .get_ack(get_ack),
        .dp_ready(dp_ready), .dp_valid(dp_valid),
        .dp_write_en(dp_write_en), .dp_cntW(dp_cntW), .dp_cntR(dp_cntR),
        .err_clr(err_clr), .put_stall(put_stall), .get_stall(get_stall),
        .wr_count(wr_count), .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        w_armed = 1'b1; r_armed = 1'b1;
        w_since = 0;    r_since = 0;
        w_ack   = 1'b0; r_ack   = 1'b0;
        w_cnt   = 0;    r_cnt   = 0;
        w_stall = 1'b0; r_stall = 1'b0;
        wn      = 0;    rn      = 0;
    endfunction

    task automatic side_update(input bit req, input bit flag, input bit clr,
                               inout bit armed, inout int since, inout bit ack,
                               inout int cnt, inout bit stall, inout int n);
        bit adm, blocked;
        n       = n + int'(ack);
        adm     = armed && req && flag;
        blocked = armed && req && !flag;
        if (clr) begin
            cnt = 0;
            stall = 1'b0;
        end else if (blocked) begin
            cnt = (cnt < L) ? cnt + 1 : L;
            if (cnt == L) stall = 1'b1;
        end else begin
            cnt = 0;
        end
        ack = adm;
        if (adm) begin
            armed = 1'b0;
            since = 0;
        end else if (!armed) begin
            since++;
            if (since >= 2 && !req) armed = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset();
        else begin
            side_update(put_req, dp_ready, err_clr, w_armed, w_since, w_ack, w_cnt, w_stall, wn);
            side_update(get_req, dp_valid, err_clr, r_armed, r_since, r_ack, r_cnt, r_stall, rn);
        end
        @(negedge clk);
    endtask

    function automatic logic [CW-1:0] exp_cnt(input int n);
        return STATS ? CW'(n) : '0;
    endfunction

    task automatic test_reset();
        #1;
        checks++;
        if ({put_ack, dp_write_en, dp_cntW, get_ack, dp_cntR, put_stall, get_stall} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outs: got %b exp 0000000",
                     {put_ack, dp_write_en, dp_cntW, get_ack, dp_cntR, put_stall, get_stall});
        end
        checks++;
        if ({wr_count, rd_count} !== '0) begin
            failures++;
            $display("FAIL reset_counts: got wr=%0d rd=%0d exp 0 0", wr_count, rd_count);
        end
        put_req = 1'b1; dp_ready = 1'b1;
        tick();
        checks++;
        if (put_ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold_ack: got %b exp 0", put_ack);
        end
        put_req = 1'b0;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_single_write();
        int pulses;
        put_req = 1'b1; dp_ready = 1'b1;
        tick();
        checks++;
        if ({put_ack, dp_write_en, dp_cntW} !== 3'b111) begin
            failures++;
            $display("FAIL single_write_strobes: got %b exp 111", {put_ack, dp_write_en, dp_cntW});
        end
        tick();
        checks++;
        if ({put_ack, dp_write_en, dp_cntW} !== 3'b000) begin
            failures++;
            $display("FAIL single_write_pulse_end: got %b exp 000", {put_ack, dp_write_en, dp_cntW});
        end
        checks++;
        if (wr_count !== exp_cnt(1)) begin
            failures++;
            $display("FAIL single_write_count: got %0d exp %0d", wr_count, exp_cnt(1));
        end
        pulses = 0;
        repeat (8) begin
            tick();
            pulses += int'(put_ack);
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL held_req_extra_acks: got %0d exp 0", pulses);
        end
        put_req = 1'b0;
        tick();
        tick();
        put_req = 1'b1;
        tick();
        checks++;
        if (put_ack !== 1'b1) begin
            failures++;
            $display("FAIL rerequest_ack: got %b exp 1", put_ack);
        end
        // Tightest legal spacing: low for exactly the two cycles after the ack.
        put_req = 1'b0;
        tick();
        tick();
        put_req = 1'b1;
        tick();
        checks++;
        if (put_ack !== 1'b1) begin
            failures++;
            $display("FAIL min_spacing_ack: got %b exp 1", put_ack);
        end
        put_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_full_stall_clr();
        put_req = 1'b1; dp_ready = 1'b0;
        repeat (L - 1) tick();
        checks++;
        if (put_stall !== 1'b0) begin
            failures++;
            $display("FAIL put_stall_early: got %b exp 0", put_stall);
        end
        err_clr = 1'b1;
        tick();
        checks++;
        if (put_stall !== 1'b0) begin
            failures++;
            $display("FAIL clr_priority: got %b exp 0", put_stall);
        end
        err_clr = 1'b0;
        repeat (L - 1) tick();
        checks++;
        if (put_stall !== 1'b0) begin
            failures++;
            $display("FAIL put_stall_restart: got %b exp 0", put_stall);
        end
        tick();
        checks++;
        if ({put_stall, put_ack, dp_write_en} !== 3'b100) begin
            failures++;
            $display("FAIL put_stall_set: got %b exp 100", {put_stall, put_ack, dp_write_en});
        end
        put_req = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (put_stall !== 1'b0) begin
            failures++;
            $display("FAIL put_stall_clear: got %b exp 0", put_stall);
        end
    endtask

    task automatic test_empty_stall();
        get_req = 1'b1; dp_valid = 1'b0;
        for (int i = 1; i <= L; i++) begin
            tick();
            checks++;
            if ({get_stall, get_ack, dp_cntR} !== {(i == L), 2'b00}) begin
                failures++;
                $display("FAIL empty_stall_cycle%0d: got %b exp %b", i,
                         {get_stall, get_ack, dp_cntR}, {(i == L), 2'b00});
            end
        end
        dp_valid = 1'b1;
        tick();
        checks++;
        if ({get_ack, dp_cntR, get_stall} !== 3'b111) begin
            failures++;
            $display("FAIL empty_release_ack: got %b exp 111", {get_ack, dp_cntR, get_stall});
        end
        get_req = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (get_stall !== 1'b0) begin
            failures++;
            $display("FAIL get_stall_clear: got %b exp 0", get_stall);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        int w0, r0;
        put_req = 1'b0; get_req = 1'b0;
        tick();
        tick();
        w0 = wn; r0 = rn;
        put_req = 1'b1; get_req = 1'b1; dp_ready = 1'b1; dp_valid = 1'b1;
        tick();
        checks++;
        if ({dp_cntW, dp_cntR, put_ack, get_ack} !== 4'b1111) begin
            failures++;
            $display("FAIL simul_strobes: got %b exp 1111", {dp_cntW, dp_cntR, put_ack, get_ack});
        end
        tick();
        checks++;
        if ({wr_count, rd_count} !== {exp_cnt(w0 + 1), exp_cnt(r0 + 1)}) begin
            failures++;
            $display("FAIL simul_counts: got wr=%0d rd=%0d exp %0d %0d",
                     wr_count, rd_count, exp_cnt(w0 + 1), exp_cnt(r0 + 1));
        end
        put_req = 1'b0; get_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_mid_reset();
        put_req = 1'b1; get_req = 1'b1; dp_ready = 1'b1; dp_valid = 1'b1;
        tick();
        checks++;
        if ({put_ack, get_ack} !== 2'b11) begin
            failures++;
            $display("FAIL mid_reset_pre: got %b exp 11", {put_ack, get_ack});
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({put_ack, dp_write_en, dp_cntW, get_ack, dp_cntR, put_stall, get_stall, wr_count, rd_count} !== '0) begin
            failures++;
            $display("FAIL mid_reset_async: got %b %b %0d %0d exp all zero",
                     {put_ack, dp_write_en, dp_cntW}, {get_ack, dp_cntR}, wr_count, rd_count);
        end
        put_req = 1'b0; get_req = 1'b0;
        tick();
        rst = 1'b1;
        put_req = 1'b1; get_req = 1'b1;
        tick();
        checks++;
        if ({put_ack, get_ack} !== 2'b11) begin
            failures++;
            $display("FAIL post_reset_idle: got %b exp 11", {put_ack, get_ack});
        end
        put_req = 1'b0; get_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_wrap();
        int base, pulses;
        base = wn; pulses = 0;
        dp_ready = 1'b1;
        repeat (17) begin
            put_req = 1'b1;
            tick();
            pulses += int'(put_ack);
            put_req = 1'b0;
            tick();
            tick();
        end
        checks++;
        if (pulses != 17) begin
            failures++;
            $display("FAIL wrap_pulses: got %0d exp 17", pulses);
        end
        checks++;
        if (wr_count !== exp_cnt(base + 17)) begin
            failures++;
            $display("FAIL wrap_count: got %0d exp %0d", wr_count, exp_cnt(base + 17));
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            put_req  = ($urandom_range(0, 9) < 7);
            get_req  = ($urandom_range(0, 9) < 7);
            dp_ready = $urandom_range(0, 1);
            dp_valid = $urandom_range(0, 1);
            err_clr  = ($urandom_range(0, 19) == 0);
            tick();
            checks++;
            if ({put_ack, dp_write_en, dp_cntW, get_ack, dp_cntR, put_stall, get_stall} !==
                {w_ack, w_ack, w_ack, r_ack, r_ack, w_stall, r_stall}) begin
                failures++;
                $display("FAIL rand_outs cycle %0d: got %b exp %b", c,
                         {put_ack, dp_write_en, dp_cntW, get_ack, dp_cntR, put_stall, get_stall},
                         {w_ack, w_ack, w_ack, r_ack, r_ack, w_stall, r_stall});
            end
            checks++;
            if ({wr_count, rd_count} !== {exp_cnt(wn), exp_cnt(rn)}) begin
                failures++;
                $display("FAIL rand_counts cycle %0d: got wr=%0d rd=%0d exp %0d %0d", c,
                         wr_count, rd_count, exp_cnt(wn), exp_cnt(rn));
            end
        end
        err_clr = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_write();
        test_full_stall_clr();
        test_empty_stall();
        test_simultaneous();
        test_mid_reset();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
